// File: rtl/sram_match_responder.sv
`default_nettype none
// ============================================================================
// Module   : sram_match_responder
// Purpose  : SRAM-side end of the port<->SRAM matching handshake. Gathers
//            match requests from every ingress port matcher, picks one
//            round-robin winner whose page demand fits the current free-page
//            count, binds this SRAM to it, and tracks page alloc/release.
// Revision : 1.0  initial release
// ============================================================================
module sram_match_responder #(
  parameter int SRAM_IDX  = 0,
  parameter int NUM_PORTS = 16,
  parameter int PAGE_CNT  = 2048
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PORTS-1:0]   match_req,
  input  logic [NUM_PORTS*7-1:0] req_pages,
  input  logic [NUM_PORTS-1:0]   match_ack,
  input  logic [NUM_PORTS-1:0]   unbind,
  input  logic                   alloc_en,
  input  logic                   release_en,
  output logic [11:0]            free_pages,
  output logic [NUM_PORTS-1:0]   grant,
  output logic                   bound,
  output logic [3:0]             bound_port,
  output logic [4:0]             bound_sram,
  output logic                   err_ovf
);

  localparam int PIDX_W = 4;
  localparam int FREE_W = 12;
  localparam int REQ_W  = 7;

  localparam logic [FREE_W-1:0] C_PAGE_MAX = FREE_W'(PAGE_CNT);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_BOUND = 2'd2;
  localparam logic [1:0] ST_COOL  = 2'd3;

  // FSM and arbitration state
  logic [1:0]           state_q, state_d;
  logic [PIDX_W-1:0]    bound_port_q, bound_port_d;
  logic [PIDX_W-1:0]    rr_q, rr_d;

  // Registered outputs
  logic [NUM_PORTS-1:0] grant_q, grant_d;
  logic                 bound_q, bound_d;

  // Page accounting
  logic [FREE_W-1:0]    free_q, free_d;
  logic                 err_q, err_d;

  // Arbitration helpers
  logic [NUM_PORTS-1:0] eligible;
  logic                 win_found;
  logic [PIDX_W-1:0]    win_idx;
  logic [PIDX_W-1:0]    scan_idx;
  logic                 alloc_ok;

  // A port is eligible when requesting and its (zero-extended) demand fits
  // into the free count as registered at the start of this cycle.
  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_elig
      assign eligible[gi] = match_req[gi] &&
        ({{(FREE_W-REQ_W){1'b0}}, req_pages[REQ_W*gi +: REQ_W]} <= free_q);
    end
  endgenerate

  // Round-robin search: first eligible port at or after rr_q, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      scan_idx = PIDX_W'((int'(rr_q) + k) % NUM_PORTS);
      if (!win_found && eligible[scan_idx]) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // State register: FSM, winner latch and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bound_port_q <= '0;
      rr_q         <= '0;
    end else begin
      state_q      <= state_d;
      bound_port_q <= bound_port_d;
      rr_q         <= rr_d;
    end
  end

  // Next-state logic. The pointer advances only on a completed handshake;
  // a withdrawn grant leaves fairness order untouched.
  always_comb begin
    state_d      = state_q;
    bound_port_d = bound_port_q;
    rr_d         = rr_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d      = ST_GRANT;
          bound_port_d = win_idx;
        end
      end
      ST_GRANT: begin
        if (match_ack[bound_port_q]) begin
          state_d = ST_BOUND;
          rr_d    = PIDX_W'((int'(bound_port_q) + 1) % NUM_PORTS);
        end else if (!match_req[bound_port_q]) begin
          state_d = ST_IDLE;
        end
      end
      ST_BOUND: begin
        if (unbind[bound_port_q]) begin
          state_d = ST_COOL;
        end
      end
      ST_COOL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so grant/bound come straight off flops.
  always_comb begin
    grant_d = '0;
    bound_d = 1'b0;
    if (state_d == ST_GRANT) begin
      grant_d[bound_port_d] = 1'b1;
    end
    if (state_d == ST_BOUND) begin
      bound_d = 1'b1;
    end
  end

  // Free-page update. Alloc only counts while bound; a simultaneous alloc
  // and release cancel out; out-of-range steps are dropped and flagged.
  always_comb begin
    alloc_ok = alloc_en && (state_q == ST_BOUND);
    free_d   = free_q;
    err_d    = err_q;
    if (alloc_ok && release_en) begin
      free_d = free_q;
    end else if (alloc_ok) begin
      if (free_q == '0) begin
        err_d = 1'b1;
      end else begin
        free_d = free_q - 1'b1;
      end
    end else if (release_en) begin
      if (free_q == C_PAGE_MAX) begin
        err_d = 1'b1;
      end else begin
        free_d = free_q + 1'b1;
      end
    end
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q <= '0;
      bound_q <= 1'b0;
      free_q  <= C_PAGE_MAX;
      err_q   <= 1'b0;
    end else begin
      grant_q <= grant_d;
      bound_q <= bound_d;
      free_q  <= free_d;
      err_q   <= err_d;
    end
  end

  assign free_pages = free_q;
  assign grant      = grant_q;
  assign bound      = bound_q;
  assign bound_port = bound_port_q;
  assign bound_sram = 5'(SRAM_IDX);
  assign err_ovf    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_match_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_match_responder
// Purpose  : Directed self-checking bench for sram_match_responder.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_match_responder;

  localparam int NP = 16;

  logic            clk;
  logic            rst;
  logic [NP-1:0]   match_req;
  logic [NP*7-1:0] req_pages;
  logic [NP-1:0]   match_ack;
  logic [NP-1:0]   unbind;
  logic            alloc_en;
  logic            release_en;
  logic [11:0]     free_pages;
  logic [NP-1:0]   grant;
  logic            bound;
  logic [3:0]      bound_port;
  logic [4:0]      bound_sram;
  logic            err_ovf;

  int n_total = 0;
  int n_bad   = 0;

  sram_match_responder #(
    .SRAM_IDX  (0),
    .NUM_PORTS (NP),
    .PAGE_CNT  (2048)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .match_req  (match_req),
    .req_pages  (req_pages),
    .match_ack  (match_ack),
    .unbind     (unbind),
    .alloc_en   (alloc_en),
    .release_en (release_en),
    .free_pages (free_pages),
    .grant      (grant),
    .bound      (bound),
    .bound_port (bound_port),
    .bound_sram (bound_sram),
    .err_ovf    (err_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle before touching inputs or sampling outputs.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rp(input int p, input int v);
    req_pages[7*p +: 7] = 7'(v);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; match_req = '0; req_pages = '0; match_ack = '0;
    unbind = '0; alloc_en = 1'b0; release_en = 1'b0;

    // T1 reset
    tick(); tick();
    rst = 1'b0;
    check("rst_free",  32'(free_pages), 32'd2048);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_bound", 32'(bound), 32'd0);
    check("rst_err",   32'(err_ovf), 32'd0);
    check("rst_bp",    32'(bound_port), 32'd0);
    check("sram_idx",  32'(bound_sram), 32'd0);

    // T2 single request, non-winner ack ignored, 3 allocs
    set_rp(5, 10); match_req[5] = 1'b1;
    tick();
    check("t2_grant", 32'(grant), 32'h0020);
    check("t2_bp",    32'(bound_port), 32'd5);
    check("t2_bound0", 32'(bound), 32'd0);
    match_ack[4] = 1'b1;
    tick();
    match_ack = '0;
    check("t2_foreign_ack", 32'(grant), 32'h0020);
    match_ack[5] = 1'b1;
    tick();
    match_ack = '0; match_req = '0;
    check("t2_bound", 32'(bound), 32'd1);
    check("t2_grant_off", 32'(grant), 32'h0);
    alloc_en = 1'b1;
    repeat (3) tick();
    alloc_en = 1'b0;
    check("t2_free", 32'(free_pages), 32'd2045);
    unbind[0] = 1'b1;
    tick();
    unbind = '0;
    check("t2_foreign_unbind", 32'(bound), 32'd1);
    unbind[5] = 1'b1;
    tick();
    unbind = '0;
    check("t2_cool_bound", 32'(bound), 32'd0);
    tick();

    // T3 round-robin after reset (rr_ptr=0)
    rst = 1'b1; tick(); rst = 1'b0;
    check("t3_free", 32'(free_pages), 32'd2048);
    set_rp(2, 1); set_rp(9, 1);
    match_req[2] = 1'b1; match_req[9] = 1'b1;
    tick();
    check("t3_grant2", 32'(grant), 32'h0004);
    match_ack[2] = 1'b1;
    tick();
    match_ack = '0;
    check("t3_bound", 32'(bound), 32'd1);
    unbind[2] = 1'b1;
    tick();
    unbind = '0;
    check("t3_cool_grant", 32'(grant), 32'h0);
    tick();
    check("t3_idle_grant", 32'(grant), 32'h0);
    tick();
    check("t3_grant9", 32'(grant), 32'h0200);
    check("t3_bp9",    32'(bound_port), 32'd9);

    // T5 withdraw: pointer must stay at 3, so port 5 beats port 2
    match_req = '0; match_req[2] = 1'b1; match_req[5] = 1'b1; set_rp(5, 1);
    tick();
    check("t5_idle_grant", 32'(grant), 32'h0);
    check("t5_idle_bound", 32'(bound), 32'd0);
    tick();
    check("t5_rr_kept", 32'(grant), 32'h0020);
    match_req = '0;
    tick();
    check("t5_drop", 32'(grant), 32'h0);

    // T4 setup: zero-page request is eligible; drain down to 4 free
    set_rp(0, 0); match_req[0] = 1'b1;
    tick();
    check("t4_zero_req", 32'(grant), 32'h0001);
    match_ack[0] = 1'b1;
    tick();
    match_ack = '0; match_req = '0;
    alloc_en = 1'b1;
    repeat (2044) tick();
    alloc_en = 1'b0;
    check("t4_free4", 32'(free_pages), 32'd4);
    unbind[0] = 1'b1;
    tick();
    unbind = '0;
    tick();

    // T4 fit: port 1 wants 5 (too many), port 3 wants 4
    set_rp(1, 5); set_rp(3, 4);
    match_req[1] = 1'b1; match_req[3] = 1'b1;
    tick();
    check("t4_grant3", 32'(grant), 32'h0008);
    check("t4_bp3",    32'(bound_port), 32'd3);
    match_req[3] = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t4_unfit", 32'(grant), 32'h0);
    end

    // T6 bounds
    set_rp(1, 0);
    tick();
    check("t6_grant1", 32'(grant), 32'h0002);
    match_ack[1] = 1'b1;
    tick();
    match_ack = '0; match_req = '0;
    alloc_en = 1'b1;
    repeat (4) tick();
    check("t6_free0", 32'(free_pages), 32'd0);
    check("t6_err0",  32'(err_ovf), 32'd0);
    tick();
    alloc_en = 1'b0;
    check("t6_under_free", 32'(free_pages), 32'd0);
    check("t6_under_err",  32'(err_ovf), 32'd1);
    release_en = 1'b1;
    repeat (100) tick();
    release_en = 1'b0;
    check("t6_free100", 32'(free_pages), 32'd100);
    alloc_en = 1'b1; release_en = 1'b1;
    tick();
    alloc_en = 1'b0; release_en = 1'b0;
    check("t6_both", 32'(free_pages), 32'd100);
    unbind[1] = 1'b1; alloc_en = 1'b1;
    tick();
    unbind = '0; alloc_en = 1'b0;
    check("t6_unbind_alloc", 32'(free_pages), 32'd99);
    check("t6_unbind_cool",  32'(bound), 32'd0);
    tick();

    // Rebind then reset mid-BOUND
    match_req[1] = 1'b1;
    tick();
    check("t6_regrant", 32'(grant), 32'h0002);
    match_ack[1] = 1'b1;
    tick();
    match_ack = '0; match_req = '0;
    check("t6_rebound", 32'(bound), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_bound", 32'(bound), 32'd0);
    check("t6_rst_free",  32'(free_pages), 32'd2048);
    check("t6_rst_err",   32'(err_ovf), 32'd0);
    check("t6_rst_bp",    32'(bound_port), 32'd0);

    // Alloc outside BOUND is ignored; release at full count flags overflow
    alloc_en = 1'b1;
    tick();
    alloc_en = 1'b0;
    check("t6_alloc_idle", 32'(free_pages), 32'd2048);
    release_en = 1'b1;
    tick();
    release_en = 1'b0;
    check("t6_over_free", 32'(free_pages), 32'd2048);
    check("t6_over_err",  32'(err_ovf), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
